pipelined_magnitude_comparator: RTL and testbench

Parametrised, pipelined successor to the team's fixed 4-bit magnitude comparator. It compares operand pairs `a` and `b` of `WIDTH` bits, unsigned or two's-complement, selected per transaction. Each result carries a valid/ready handshake with full backpressure. The block also keeps saturating counts of greater, less and equal results. It sits between a producer of operand pairs, such as a sample stream or sort network stage, and a consumer of comparison flags.

---
 rtl/pipelined_magnitude_comparator_if.sv | 31 +++
 rtl/pipelined_magnitude_comparator.sv | 123 ++++++++++++
 tb/tb_pipelined_magnitude_comparator.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_magnitude_comparator_if.sv
// Handshake and result bus of the pipelined magnitude comparator.
// The slave modport is the comparator; the master modport is the producer/consumer side.
interface pipelined_magnitude_comparator_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  logic               inValid;
  logic               inReady;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signedMode;
  logic               outValid;
  logic               outReady;
  logic               aGreater;
  logic               bGreater;
  logic               aEqualsb;
  logic               countClear;
  logic [COUNT_W-1:0] gtCount;
  logic [COUNT_W-1:0] ltCount;
  logic [COUNT_W-1:0] eqCount;

  modport slave (
    input  inValid, a, b, signedMode, outReady, countClear,
    output inReady, outValid, aGreater, bGreater, aEqualsb, gtCount, ltCount, eqCount
  );

  modport master (
    output inValid, a, b, signedMode, outReady, countClear,
    input  inReady, outValid, aGreater, bGreater, aEqualsb, gtCount, ltCount, eqCount
  );
endinterface

// File: rtl/pipelined_magnitude_comparator.sv
// Two-stage valid/ready magnitude comparator (unsigned or two's-complement per pair)
// with saturating counts of delivered greater/less/equal results.
module pipelined_magnitude_comparator #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input logic                               clk,
  input logic                               rst,
  pipelined_magnitude_comparator_if.slave   bus
);

  localparam logic [COUNT_W-1:0] C_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] C_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] C_ZERO = {COUNT_W{1'b0}};

  // Returns {gt, lt, eq}; signed mode flips the MSBs so the unsigned scan applies.
  function automatic logic [2:0] f_compare(input logic [WIDTH-1:0] i_a,
                                           input logic [WIDTH-1:0] i_b,
                                           input logic             i_signed);
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_gt;
    logic             w_hi_eq;
    logic             w_eq;
    w_x = i_a;
    w_y = i_b;
    if (i_signed) begin
      w_x[WIDTH-1] = ~i_a[WIDTH-1];
      w_y[WIDTH-1] = ~i_b[WIDTH-1];
    end
    w_gt    = 1'b0;
    w_hi_eq = 1'b1;
    for (int i = WIDTH - 1; i >= 32'sd0; i--) begin
      w_gt    = w_gt | (w_hi_eq & w_x[i] & ~w_y[i]);
      w_hi_eq = w_hi_eq & ~(w_x[i] ^ w_y[i]);
    end
    w_eq = &(~(w_x ^ w_y));
    return {w_gt, ~w_gt & ~w_eq, w_eq};
  endfunction

  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic               r_s1_signed;
  logic               r_s2_valid;
  logic               r_gt;
  logic               r_lt;
  logic               r_eq;
  logic [COUNT_W-1:0] r_gt_cnt;
  logic [COUNT_W-1:0] r_lt_cnt;
  logic [COUNT_W-1:0] r_eq_cnt;

  logic               w_s2_load;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_out_hs;
  logic [2:0]         w_cmp;

  assign w_s2_load  = r_s1_valid && (!r_s2_valid || bus.outReady);
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_accept   = bus.inValid && w_in_ready;
  assign w_out_hs   = r_s2_valid && bus.outReady;
  assign w_cmp      = f_compare(r_s1_a, r_s1_b, r_s1_signed);

  // Stage 1: operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= {WIDTH{1'b0}};
      r_s1_b      <= {WIDTH{1'b0}};
      r_s1_signed <= 1'b0;
    end else begin
      r_s1_valid <= w_accept || (r_s1_valid && !w_s2_load);
      if (w_accept) begin
        r_s1_a      <= bus.a;
        r_s1_b      <= bus.b;
        r_s1_signed <= bus.signedMode;
      end
    end
  end

  // Stage 2: result flags, held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_gt       <= 1'b0;
      r_lt       <= 1'b0;
      r_eq       <= 1'b0;
    end else begin
      r_s2_valid <= w_s2_load || (r_s2_valid && !bus.outReady);
      if (w_s2_load) begin
        {r_gt, r_lt, r_eq} <= w_cmp;
      end
    end
  end

  // Saturating result counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gt_cnt <= C_ZERO;
      r_lt_cnt <= C_ZERO;
      r_eq_cnt <= C_ZERO;
    end else if (bus.countClear) begin
      r_gt_cnt <= C_ZERO;
      r_lt_cnt <= C_ZERO;
      r_eq_cnt <= C_ZERO;
    end else if (w_out_hs) begin
      if (r_gt && (r_gt_cnt != C_MAX)) r_gt_cnt <= r_gt_cnt + C_ONE;
      if (r_lt && (r_lt_cnt != C_MAX)) r_lt_cnt <= r_lt_cnt + C_ONE;
      if (r_eq && (r_eq_cnt != C_MAX)) r_eq_cnt <= r_eq_cnt + C_ONE;
    end
  end

  assign bus.inReady  = w_in_ready;
  assign bus.outValid = r_s2_valid;
  assign bus.aGreater = r_gt;
  assign bus.bGreater = r_lt;
  assign bus.aEqualsb = r_eq;
  assign bus.gtCount  = r_gt_cnt;
  assign bus.ltCount  = r_lt_cnt;
  assign bus.eqCount  = r_eq_cnt;

endmodule

// File: tb/tb_pipelined_magnitude_comparator.sv
// Scoreboard bench: an 8-bit/2-bit-counter instance for directed cases and a
// 13-bit instance for randomized traffic, both checked against an arithmetic model.
module tb_pipelined_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_magnitude_comparator_if #(.WIDTH(8),  .COUNT_W(2))  if8 ();
  pipelined_magnitude_comparator_if #(.WIDTH(13), .COUNT_W(16)) if13 ();

  pipelined_magnitude_comparator #(.WIDTH(8), .COUNT_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .bus(if8));
  pipelined_magnitude_comparator #(.WIDTH(13), .COUNT_W(16)) u_dut13 (
    .clk(clk), .rst(rst), .bus(if13));

  int tests = 0;
  int fails = 0;

  logic [2:0] q8[$];
  logic [2:0] q13[$];
  int m8_gt = 0, m8_lt = 0, m8_eq = 0;
  int m13_gt = 0, m13_lt = 0, m13_eq = 0;
  logic       p8_stall = 1'b0, p13_stall = 1'b0;
  logic [2:0] p8_flags, p13_flags;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers, compare with plain arithmetic.
  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                         input logic sm, input int w);
    longint va, vb;
    va = longint'(a);
    vb = longint'(b);
    if (sm && a[w-1]) va = va - (longint'(1) << w);
    if (sm && b[w-1]) vb = vb - (longint'(1) << w);
    return {va > vb, va < vb, va == vb};
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    logic [2:0] exp;
    if (rst) begin
      q8.delete();
      m8_gt = 0; m8_lt = 0; m8_eq = 0;
      p8_stall = 1'b0;
    end else begin
      exp = 3'b000;
      chk("cnt8_gt", 32'(if8.gtCount), m8_gt);
      chk("cnt8_lt", 32'(if8.ltCount), m8_lt);
      chk("cnt8_eq", 32'(if8.eqCount), m8_eq);
      if (p8_stall) begin
        chk("stall8_valid", 32'(if8.outValid), 1);
        chk("stall8_flags", 32'({if8.aGreater, if8.bGreater, if8.aEqualsb}), 32'(p8_flags));
      end
      if (if8.outValid) begin
        chk("onehot8", 32'(if8.aGreater) + 32'(if8.bGreater) + 32'(if8.aEqualsb), 1);
        if (if8.outReady) begin
          if (q8.size() == 0) begin
            chk("unexpected8", 32'(q8.size()), 1);
          end else begin
            exp = q8.pop_front();
            chk("flags8", 32'({if8.aGreater, if8.bGreater, if8.aEqualsb}), 32'(exp));
          end
        end
      end
      if (if8.countClear) begin
        m8_gt = 0; m8_lt = 0; m8_eq = 0;
      end else if (if8.outValid && if8.outReady) begin
        if (exp[2]) m8_gt = sat_inc(m8_gt, 3);
        if (exp[1]) m8_lt = sat_inc(m8_lt, 3);
        if (exp[0]) m8_eq = sat_inc(m8_eq, 3);
      end
      p8_stall = if8.outValid && !if8.outReady;
      p8_flags = {if8.aGreater, if8.bGreater, if8.aEqualsb};
    end
  end

  // Monitor for the 13-bit instance.
  always @(negedge clk) begin
    logic [2:0] exp;
    if (rst) begin
      q13.delete();
      m13_gt = 0; m13_lt = 0; m13_eq = 0;
      p13_stall = 1'b0;
    end else begin
      exp = 3'b000;
      chk("cnt13_gt", 32'(if13.gtCount), m13_gt);
      chk("cnt13_lt", 32'(if13.ltCount), m13_lt);
      chk("cnt13_eq", 32'(if13.eqCount), m13_eq);
      if (p13_stall) begin
        chk("stall13_valid", 32'(if13.outValid), 1);
        chk("stall13_flags", 32'({if13.aGreater, if13.bGreater, if13.aEqualsb}), 32'(p13_flags));
      end
      if (if13.outValid) begin
        chk("onehot13", 32'(if13.aGreater) + 32'(if13.bGreater) + 32'(if13.aEqualsb), 1);
        if (if13.outReady) begin
          if (q13.size() == 0) begin
            chk("unexpected13", 32'(q13.size()), 1);
          end else begin
            exp = q13.pop_front();
            chk("flags13", 32'({if13.aGreater, if13.bGreater, if13.aEqualsb}), 32'(exp));
          end
        end
      end
      if (if13.countClear) begin
        m13_gt = 0; m13_lt = 0; m13_eq = 0;
      end else if (if13.outValid && if13.outReady) begin
        if (exp[2]) m13_gt = sat_inc(m13_gt, 65535);
        if (exp[1]) m13_lt = sat_inc(m13_lt, 65535);
        if (exp[0]) m13_eq = sat_inc(m13_eq, 65535);
      end
      p13_stall = if13.outValid && !if13.outReady;
      p13_flags = {if13.aGreater, if13.bGreater, if13.aEqualsb};
    end
  end

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    bit ok;
    ok = 1'b0;
    if8.a = a; if8.b = b; if8.signedMode = sm; if8.inValid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (if8.inReady) begin
        q8.push_back(ref_cmp(32'(a), 32'(b), sm, 8));
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send8_timeout", 0, 1);
    @(posedge clk); #1;
    if8.inValid = 1'b0;
  endtask

  initial begin
    int sent, cyc, n_gt, n_lt, n_eq;
    logic pend;
    logic [12:0] ra, rb;
    logic rsm;
    logic [2:0] e;

    if8.inValid = 1'b0; if8.a = '0; if8.b = '0; if8.signedMode = 1'b0;
    if8.outReady = 1'b1; if8.countClear = 1'b0;
    if13.inValid = 1'b0; if13.a = '0; if13.b = '0; if13.signedMode = 1'b0;
    if13.outReady = 1'b1; if13.countClear = 1'b0;

    #3;
    chk("rst_outValid", 32'(if8.outValid), 0);
    chk("rst_flags", 32'({if8.aGreater, if8.bGreater, if8.aEqualsb}), 0);
    chk("rst_counts", 32'({if8.gtCount, if8.ltCount, if8.eqCount}), 0);
    chk("rst_inReady", 32'(if8.inReady), 1);
    chk("rst_inReady13", 32'(if13.inReady), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Unsigned compare with latency check.
    send8(8'hF0, 8'h0F, 1'b0);
    chk("lat_not_early", 32'(if8.outValid), 0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(if8.outValid), 1);
    chk("uns_flags", 32'({if8.aGreater, if8.bGreater, if8.aEqualsb}), 32'(3'b100));
    @(posedge clk); #1;
    chk("uns_gtCount", 32'(if8.gtCount), 1);

    // Signed compares.
    send8(8'hF0, 8'h0F, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("sgn_ltCount", 32'(if8.ltCount), 1);
    send8(8'h80, 8'h80, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("sgn_eqCount", 32'(if8.eqCount), 1);

    // Backpressure: two buffered, third waits, then drain in order.
    if8.outReady = 1'b0;
    send8(8'h20, 8'h10, 1'b0);
    send8(8'h01, 8'h02, 1'b0);
    chk("bp_inReady_low", 32'(if8.inReady), 0);
    fork
      send8(8'h55, 8'h55, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_ready", 32'(if8.inReady), 0);
        end
        @(posedge clk); #1 if8.outReady = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("bp_drain_valid", 32'(if8.outValid), 1);
        end
      end
    join
    @(posedge clk); #1;
    chk("bp_counts", 32'({if8.gtCount, if8.ltCount, if8.eqCount}), 32'({2'd2, 2'd2, 2'd2}));

    // Asynchronous reset with both stages full.
    if8.outReady = 1'b0;
    send8(8'h30, 8'h31, 1'b0);
    send8(8'h40, 8'h40, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_outValid", 32'(if8.outValid), 0);
    chk("arst_flags", 32'({if8.aGreater, if8.bGreater, if8.aEqualsb}), 0);
    chk("arst_counts", 32'({if8.gtCount, if8.ltCount, if8.eqCount}), 0);
    chk("arst_inReady", 32'(if8.inReady), 1);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    if8.outReady = 1'b1;
    send8(8'h03, 8'h09, 1'b0);
    chk("post_rst_not_early", 32'(if8.outValid), 0);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(if8.outValid), 1);
    chk("post_rst_flags", 32'({if8.aGreater, if8.bGreater, if8.aEqualsb}), 32'(3'b010));
    @(posedge clk); #1;
    chk("post_rst_lt", 32'(if8.ltCount), 1);

    // Saturation of a 2-bit counter, then clear racing a handshake.
    for (int k = 0; k < 5; k++) send8(8'(k * 17), 8'(k * 17), k[0]);
    repeat (3) @(posedge clk); #1;
    chk("sat_eq", 32'(if8.eqCount), 3);
    send8(8'h66, 8'h66, 1'b0);
    @(posedge clk); #1;
    if8.countClear = 1'b1;
    chk("clr_same_cycle_hs", 32'(if8.outValid && if8.outReady), 1);
    @(posedge clk); #1;
    if8.countClear = 1'b0;
    chk("clr_eq", 32'(if8.eqCount), 0);
    chk("clr_lt", 32'(if8.ltCount), 0);

    // Randomized traffic on the 13-bit instance.
    sent = 0; cyc = 0; pend = 1'b0; n_gt = 0; n_lt = 0; n_eq = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          ra = 13'($urandom);
          rb = ($urandom_range(0, 7) == 0) ? ra : 13'($urandom);
          if ($urandom_range(0, 15) == 0) begin ra = 13'h1000; rb = 13'h0FFF; end
          rsm = 1'($urandom);
          if13.a = ra; if13.b = rb; if13.signedMode = rsm;
          if13.inValid = 1'b1;
          pend = 1'b1;
        end else begin
          if13.inValid = 1'b0;
        end
      end
      if13.outReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pend && if13.inReady) begin
        e = ref_cmp(32'(ra), 32'(rb), rsm, 13);
        q13.push_back(e);
        n_gt += int'(e[2]); n_lt += int'(e[1]); n_eq += int'(e[0]);
        sent++;
        pend = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if13.inValid = 1'b0;
    if13.outReady = 1'b1;
    chk("rand_all_sent", 32'(sent), 10000);
    for (int t = 0; t < 20 && q13.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk); #1;
    chk("rand_drained", 32'(q13.size()), 0);
    chk("rand_gt_total", 32'(if13.gtCount), 32'(n_gt));
    chk("rand_lt_total", 32'(if13.ltCount), 32'(n_lt));
    chk("rand_eq_total", 32'(if13.eqCount), 32'(n_eq));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
